// File: rtl/switch_debouncer_if.sv
// Signal bundle between a raw mechanical switch and the debouncer feeding the relay chain.
// The master side is the debouncer; the slave side supplies the raw contact and consumes the clean level.
interface switch_debouncer_if #(
  parameter int CNT_W = 8
);
  logic             raw_switch;
  logic             switch_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic             settling;
  logic [CNT_W-1:0] bounce_count;

  modport master (
    input  raw_switch,
    output switch_out,
    output rise_pulse,
    output fall_pulse,
    output settling,
    output bounce_count
  );

  modport slave (
    output raw_switch,
    input  switch_out,
    input  rise_pulse,
    input  fall_pulse,
    input  settling,
    input  bounce_count
  );
endinterface

// File: rtl/switch_debouncer.sv
// Debounces a bouncy raw contact into a stable level for the first relay's switch input:
// 2-flop synchronizer, settle-time FSM, registered edge pulses and an optional toggle mode.
module switch_debouncer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int TOGGLE_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  switch_debouncer_if.master   dbif
);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_SETTLE_HI = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_SETTLE_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);

  logic             sync1_r;
  logic             sync2_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sw_r;
  logic             rise_r;
  logic             fall_r;
  logic             settling_r;
  logic [CNT_W-1:0] bounce_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Two-flop synchronizer for the asynchronous raw contact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= dbif.raw_switch;
      sync2_r <= sync1_r;
    end
  end

  // Settle-time FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_STABLE_LO;
      cnt_r      <= CNT_ZERO;
      sw_r       <= 1'b0;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
      settling_r <= 1'b0;
      bounce_r   <= CNT_ZERO;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        ST_STABLE_LO: begin
          if (sync2_r) begin
            state_r    <= ST_SETTLE_HI;
            cnt_r      <= CNT_ONE;
            settling_r <= 1'b1;
          end else begin
            state_r    <= ST_STABLE_LO;
            settling_r <= 1'b0;
          end
        end
        ST_SETTLE_HI: begin
          if (!sync2_r) begin
            state_r    <= ST_STABLE_LO;
            cnt_r      <= CNT_ZERO;
            settling_r <= 1'b0;
            bounce_r   <= sat_inc(bounce_r);
          end else if (cnt_r == CNT_SETTLE) begin
            state_r    <= ST_STABLE_HI;
            cnt_r      <= CNT_ZERO;
            settling_r <= 1'b0;
            // In toggle mode each accepted press flips the output and pulses the matching edge.
            if (TOGGLE_MODE != 0) begin
              sw_r   <= ~sw_r;
              rise_r <= ~sw_r;
              fall_r <= sw_r;
            end else begin
              sw_r   <= 1'b1;
              rise_r <= 1'b1;
            end
          end else begin
            cnt_r      <= cnt_r + CNT_ONE;
            settling_r <= 1'b1;
          end
        end
        ST_STABLE_HI: begin
          if (!sync2_r) begin
            state_r    <= ST_SETTLE_LO;
            cnt_r      <= CNT_ONE;
            settling_r <= 1'b1;
          end else begin
            state_r    <= ST_STABLE_HI;
            settling_r <= 1'b0;
          end
        end
        ST_SETTLE_LO: begin
          if (sync2_r) begin
            state_r    <= ST_STABLE_HI;
            cnt_r      <= CNT_ZERO;
            settling_r <= 1'b0;
            bounce_r   <= sat_inc(bounce_r);
          end else if (cnt_r == CNT_SETTLE) begin
            state_r    <= ST_STABLE_LO;
            cnt_r      <= CNT_ZERO;
            settling_r <= 1'b0;
            // A released button leaves a toggled output untouched.
            if (TOGGLE_MODE != 0) begin
              sw_r <= sw_r;
            end else begin
              sw_r   <= 1'b0;
              fall_r <= 1'b1;
            end
          end else begin
            cnt_r      <= cnt_r + CNT_ONE;
            settling_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_STABLE_LO;
          cnt_r      <= CNT_ZERO;
          settling_r <= 1'b0;
        end
      endcase
    end
  end

  assign dbif.switch_out   = sw_r;
  assign dbif.rise_pulse   = rise_r;
  assign dbif.fall_pulse   = fall_r;
  assign dbif.settling     = settling_r;
  assign dbif.bounce_count = bounce_r;

endmodule
